// File: rtl/clock_divider_prog_if.sv
// Control/status bundle for clock_divider_prog.
// The restart signal exists only when CLOCK_DIVIDER_RESTART_EN is defined.
interface clock_divider_prog_if #(
  parameter int unsigned NUM_BITS = 26
);
  logic                enable;
  logic                load;
  logic [NUM_BITS-1:0] div_in;
  logic [NUM_BITS-1:0] high_in;
`ifdef CLOCK_DIVIDER_RESTART_EN
  logic                restart;
`endif
  logic                clock_out;
  logic                tick;
  logic                pending;

  modport master (
`ifdef CLOCK_DIVIDER_RESTART_EN
    output restart,
`endif
    output enable, load, div_in, high_in,
    input  clock_out, tick, pending
  );

  modport slave (
`ifdef CLOCK_DIVIDER_RESTART_EN
    input  restart,
`endif
    input  enable, load, div_in, high_in,
    output clock_out, tick, pending
  );
endinterface

// File: rtl/clock_divider_prog.sv
// Runtime-programmable clock divider with glitch-free period/high-time update.
// New settings are written to a shadow register and take effect only when a
// period wraps, so clock_out never produces a runt pulse.
// Optional feature macro: CLOCK_DIVIDER_RESTART_EN (adds a forced-wrap input).
module clock_divider_prog #(
  parameter int unsigned NUM_BITS     = 26,
  parameter int unsigned DEFAULT_DIV  = 50_000_000,
  parameter int unsigned DEFAULT_HIGH = 25_000_000
) (
  input  logic                 clock_in,
  input  logic                 reset_n,
  clock_divider_prog_if.slave  bus
);

  typedef logic [NUM_BITS-1:0] cnt_t;

  localparam cnt_t DefDiv  = cnt_t'(DEFAULT_DIV);
  localparam cnt_t DefHigh = cnt_t'(DEFAULT_HIGH);
  localparam cnt_t MinDiv  = cnt_t'(2);

  cnt_t active_div_q,  active_div_d;
  cnt_t active_high_q, active_high_d;
  cnt_t shadow_div_q,  shadow_div_d;
  cnt_t shadow_high_q, shadow_high_d;
  cnt_t count_q,       count_d;
  logic pending_q,     pending_d;
  logic clock_out_q,   clock_out_d;
  logic tick_q,        tick_d;

  cnt_t period;
  logic restart_req;
  logic wrap;
  logic apply;

  // Effective period clamps 0/1 to 2; wrap is a natural end-of-period or a forced restart.
  always_comb begin
    period = (active_div_q < MinDiv) ? MinDiv : active_div_q;
`ifdef CLOCK_DIVIDER_RESTART_EN
    restart_req = bus.restart;
`else
    restart_req = 1'b0;
`endif
    wrap  = bus.enable && ((count_q == period - cnt_t'(1)) || restart_req);
    apply = wrap && pending_q;
  end

  // Next-state: apply shadow at wrap, advance counter, then capture any new load.
  always_comb begin
    active_div_d  = active_div_q;
    active_high_d = active_high_q;
    shadow_div_d  = shadow_div_q;
    shadow_high_d = shadow_high_q;
    count_d       = count_q;
    pending_d     = pending_q;
    clock_out_d   = clock_out_q;
    tick_d        = 1'b0;

    if (apply) begin
      active_div_d  = shadow_div_q;
      active_high_d = shadow_high_q;
      pending_d     = 1'b0;
    end

    if (bus.enable) begin
      if (wrap) begin
        // The period starting here already uses the freshly applied high time.
        count_d     = '0;
        tick_d      = 1'b1;
        clock_out_d = (active_high_d != '0);
      end else begin
        count_d     = count_q + cnt_t'(1);
        clock_out_d = (count_d < active_high_q);
      end
    end

    // A load on a wrap edge lands after the apply, so it waits for the next wrap.
    if (bus.load) begin
      shadow_div_d  = bus.div_in;
      shadow_high_d = bus.high_in;
      pending_d     = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset to the default ratio.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      active_div_q  <= DefDiv;
      active_high_q <= DefHigh;
      shadow_div_q  <= DefDiv;
      shadow_high_q <= DefHigh;
      count_q       <= DefDiv - cnt_t'(1);
      pending_q     <= 1'b0;
      clock_out_q   <= 1'b0;
      tick_q        <= 1'b0;
    end else begin
      active_div_q  <= active_div_d;
      active_high_q <= active_high_d;
      shadow_div_q  <= shadow_div_d;
      shadow_high_q <= shadow_high_d;
      count_q       <= count_d;
      pending_q     <= pending_d;
      clock_out_q   <= clock_out_d;
      tick_q        <= tick_d;
    end
  end

  assign bus.clock_out = clock_out_q;
  assign bus.tick      = tick_q;
  assign bus.pending   = pending_q;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Directed self-checking bench for clock_divider_prog (DEFAULT_DIV=4, DEFAULT_HIGH=2).
// The restart scenario runs only when CLOCK_DIVIDER_RESTART_EN is defined.
module tb_clock_divider_prog;

  localparam int unsigned NumBits = 8;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  clock_divider_prog_if #(.NUM_BITS(NumBits)) bus ();

  clock_divider_prog #(
    .NUM_BITS    (NumBits),
    .DEFAULT_DIV (4),
    .DEFAULT_HIGH(2)
  ) dut (
    .clock_in(clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step n edges; phase k (mod p) of a period with high time h is expected on each.
  task automatic expect_run(input string tag, input int start, input int n,
                            input int p, input int h);
    for (int k = start; k < start + n; k++) begin
      int ph;
      ph = k % p;
      step();
      check({tag, "_co"}, 32'(bus.clock_out), 32'(ph < h));
      check({tag, "_tick"}, 32'(bus.tick), 32'(ph == 0));
    end
  endtask

  task automatic load_vals(input int d, input int h);
    bus.load    = 1'b1;
    bus.div_in  = NumBits'(d);
    bus.high_in = NumBits'(h);
  endtask

  task automatic check_state(input string tag, input logic co, input logic tk, input logic pd);
    check({tag, "_co"}, 32'(bus.clock_out), 32'(co));
    check({tag, "_tick"}, 32'(bus.tick), 32'(tk));
    check({tag, "_pend"}, 32'(bus.pending), 32'(pd));
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    rst_n       = 1'b0;
    bus.enable  = 1'b0;
    bus.load    = 1'b0;
    bus.div_in  = '0;
    bus.high_in = '0;
`ifdef CLOCK_DIVIDER_RESTART_EN
    bus.restart = 1'b0;
`endif

    // Reset state
    step();
    check_state("rst", 1'b0, 1'b0, 1'b0);
    rst_n      = 1'b1;
    bus.enable = 1'b1;

    // Defaults: 1,1,0,0 with tick at each period start
    expect_run("def", 0, 8, 4, 2);
    check("def_pend", 32'(bus.pending), 32'd0);

    // Mid-period load 6/1: old pattern finishes, then 1,0,0,0,0,0
    expect_run("def2", 0, 2, 4, 2);
    load_vals(6, 1);
    step();
    bus.load = 1'b0;
    check_state("ld6_a", 1'b0, 1'b0, 1'b1);
    step();
    check_state("ld6_b", 1'b0, 1'b0, 1'b1);
    expect_run("p6h1", 0, 12, 6, 1);
    check("p6h1_pend", 32'(bus.pending), 32'd0);

    // div 0 clamps to 2, high 5 >= P keeps clock_out high
    expect_run("p6h1b", 0, 1, 6, 1);
    load_vals(0, 5);
    step();
    bus.load = 1'b0;
    check_state("ld0_a", 1'b0, 1'b0, 1'b1);
    expect_run("ld0_tail", 2, 4, 6, 1);
    expect_run("p2h5", 0, 6, 2, 5);
    check("p2h5_pend", 32'(bus.pending), 32'd0);

    // high 0: load lands on a wrap with nothing pending, applies one period later
    load_vals(0, 0);
    step();
    bus.load = 1'b0;
    check_state("h0_a", 1'b1, 1'b1, 1'b1);
    step();
    check_state("h0_b", 1'b1, 1'b0, 1'b1);
    expect_run("p2h0", 0, 6, 2, 0);
    check("p2h0_pend", 32'(bus.pending), 32'd0);

    // Switch to 6/3, then freeze mid-high-phase for 3 cycles
    load_vals(6, 3);
    step();
    bus.load = 1'b0;
    check_state("p6h3_a", 1'b0, 1'b1, 1'b1);
    step();
    check_state("p6h3_b", 1'b0, 1'b0, 1'b1);
    expect_run("p6h3", 0, 2, 6, 3);
    bus.enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_state("frz", 1'b1, 1'b0, 1'b0);
    end
    bus.enable = 1'b1;
    expect_run("resume", 2, 10, 6, 3);

    // Load A mid-period, then load B exactly on the wrap: A applies now, B next period
    expect_run("pre_a", 0, 1, 6, 3);
    load_vals(4, 1);
    step();
    bus.load = 1'b0;
    check_state("ldA", 1'b1, 1'b0, 1'b1);
    expect_run("ldA_tail", 2, 4, 6, 3);
    load_vals(3, 2);
    step();
    bus.load = 1'b0;
    check_state("ldB_wrap", 1'b1, 1'b1, 1'b1);
    expect_run("p4h1", 1, 3, 4, 1);
    check("p4h1_pend", 32'(bus.pending), 32'd1);
    expect_run("p3h2", 0, 6, 3, 2);
    check("p3h2_pend", 32'(bus.pending), 32'd0);

    // Asynchronous reset mid-period drops outputs and discards the pending shadow
    load_vals(5, 5);
    step();
    bus.load = 1'b0;
    check_state("pre_rst", 1'b1, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_state("async_rst", 1'b0, 1'b0, 1'b0);
    step();
    check_state("rst_hold", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    expect_run("def3", 0, 8, 4, 2);
    check("def3_pend", 32'(bus.pending), 32'd0);

`ifdef CLOCK_DIVIDER_RESTART_EN
    // P=8, restart at count 3 forces a fresh full period
    load_vals(8, 4);
    step();
    bus.load = 1'b0;
    check_state("r_ld", 1'b1, 1'b1, 1'b1);
    expect_run("r_old", 1, 3, 4, 2);
    expect_run("p8h4", 0, 4, 8, 4);
    bus.restart = 1'b1;
    step();
    bus.restart = 1'b0;
    check_state("restart", 1'b1, 1'b1, 1'b0);
    expect_run("r_full", 1, 8, 8, 4);
    // Restart with enable low is ignored
    bus.enable  = 1'b0;
    bus.restart = 1'b1;
    step();
    bus.restart = 1'b0;
    bus.enable  = 1'b1;
    check_state("r_dis", 1'b1, 1'b0, 1'b0);
    expect_run("r_cont", 1, 7, 8, 4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clock_divider_prog.md
Name: clock_divider_prog

Overview:
- Runtime-programmable successor to the fixed-ratio clock divisor.
- Generates a divided clock_out with programmable period and high time, plus a one-cycle tick strobe at each period start.
- Period and high time load through a shadow register and apply only at a period boundary, so clock_out never glitches.
- Feeds LED, display-scan and FSM timebases from the board clock.

Parameters:
- NUM_BITS, 26, width of the counter and the period/high-time fields.
- DEFAULT_DIV, 50_000_000, period in clock_in cycles after reset. Must be >= 2 and < 2^NUM_BITS.
- DEFAULT_HIGH, 25_000_000, clock_out high time in clock_in cycles after reset.

Ports:
- clock_in, input, 1, the only clock.
- reset_n, input, 1, reset; asynchronous, active-low.
- enable, input, 1, count-enable. When low, count and clock_out freeze.
- load, input, 1, single-cycle strobe that captures div_in and high_in into the shadow registers.
- div_in, input, NUM_BITS, requested period in cycles.
- high_in, input, NUM_BITS, requested high time in cycles.
- clock_out, output, 1, divided clock (registered).
- tick, output, 1, one-cycle pulse on the cycle clock_out starts a period (registered).
- pending, output, 1, high while shadow values wait for a boundary.

Behaviour:
- Reset (asynchronous, active-low):
  - active_div = DEFAULT_DIV, active_high = DEFAULT_HIGH.
  - Shadow registers = the same defaults.
  - count = DEFAULT_DIV-1.
  - clock_out = 0, tick = 0, pending = 0.
- Effective period P = max(active_div, 2). div_in values 0 and 1 clamp to 2.
- Enabled edge:
  - count_next = (count == P-1) ? 0 : count+1.
  - clock_out <= (count_next < active_high).
  - tick <= (count_next == 0).
- Consequences of the enabled-edge rules:
  - The first enabled edge after reset starts a period: clock_out rises (if high > 0) and tick = 1.
  - clock_out is high for min(H,P) cycles and low for P-min(H,P) cycles.
  - H = 0 gives clock_out constantly 0. H >= P gives clock_out constantly 1. tick still pulses every P cycles in both cases.
- enable low:
  - count and clock_out hold.
  - tick <= 0.
  - load is still accepted.
- Load:
  - load = 1 captures div_in/high_in into the shadow registers; pending <= 1.
  - A second load while pending overwrites the shadow (last write wins).
- Apply at wrap (enabled edge with count == P-1 while pending = 1):
  - active_div/active_high <= shadow; pending <= 0.
  - The period starting at this edge already uses the new values: clock_out computed with new high, tick = 1, count = 0.
- Load in the same cycle as a wrap:
  - If pending was 1, the prior shadow values apply at this wrap.
  - The new values are captured and pending stays 1; they apply at the following wrap.
- Counter width: count never exceeds P-1. P uses NUM_BITS unsigned arithmetic with no overflow path.
- Reset mid-period: immediate asynchronous return to the reset state. The shadow registers and pending are lost.

Optional Feature:
- Macro: CLOCK_DIVIDER_RESTART_EN.
- Defined:
  - Adds input port restart (1 bit).
  - restart = 1 on an enabled edge forces an immediate wrap: count <= 0, tick <= 1, clock_out <= (active_high > 0).
  - Any pending shadow is applied first, exactly as at a natural wrap.
  - restart takes priority over normal counting; with enable low it is ignored.
- Not defined: no restart port; periods only begin at natural wraps.

Test Plan:
- Reset with DEFAULT_DIV = 4, DEFAULT_HIGH = 2, enable = 1 -> clock_out 1,1,0,0 repeating; tick on cycles 1, 5, 9; pending = 0.
- Load div_in = 6, high_in = 1 mid-period -> pending = 1 until the next wrap. Then clock_out 1,0,0,0,0,0 repeating, tick every 6 cycles, no runt pulse at the transition.
- Load div_in = 0 and high_in = 5 -> P clamps to 2 and clock_out is constantly 1, tick every 2 cycles. Then load high_in = 0 -> clock_out constantly 0.
- Drop enable for 3 cycles mid-high-phase -> clock_out stays 1, tick stays 0, count frozen; on re-enable the period resumes with no lost or extra cycles.
- Load a value on the exact wrap cycle, with a prior load already pending -> prior values take effect at this wrap, pending stays 1, and the new values take effect one period later. Then assert reset_n = 0 mid-period -> all outputs 0 asynchronously and the defaults restore.
- With CLOCK_DIVIDER_RESTART_EN defined, P = 8, and restart pulsed at count = 3 -> next cycle tick = 1, count = 0, clock_out high, and a full 8-cycle period follows.
